// File: rtl/bidir_pad_pkg.sv
// Shared types and line-level constants for the half-duplex single-wire pad link.
package bidir_pad_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TURN     = 3'd4,
        RX_WAIT  = 3'd5,
        RX_DATA  = 3'd6,
        RX_STOP  = 3'd7
    } bidir_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchroniser for an asynchronous single-bit pad input.
module pad_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Both stages reset to the idle level so no false edge appears at release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/bidir_pad_link.sv
// Half-duplex link: sends one byte out of a bidirectional pad, turns the pad
// around and receives one response frame back through the pad receiver.
module bidir_pad_link
    import bidir_pad_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TURN_CYC   = 2,
    parameter int RX_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_frame_err,
    output logic              rx_timeout,
    output logic              busy,
    output logic              pad_din,
    output logic              pad_en,
    output logic              pad_ren,
    input  logic              pad_dout
);

    localparam int CNT_MAX = (DATA_W > TURN_CYC) ? DATA_W : TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(RX_TIMEOUT + 1);

    bidir_state_t      state_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              pad_din_q;
    logic              pad_en_q;
    logic              pad_ren_q;
    logic              tx_ready_q;
    logic              rx_bit;

    pad_sync #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_pad_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_dout),
        .q     (rx_bit)
    );

    // Terminal pulses are decoded from the state and synchroniser flops so they
    // coincide with the sampled stop bit / last wait cycle; the FSM leaves next edge.
    always_comb begin
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        rx_timeout   = 1'b0;
        if (state_q == RX_STOP) begin
            if (rx_bit == STOP_BIT) begin
                rx_valid = 1'b1;
            end else begin
                rx_frame_err = 1'b1;
            end
        end else if ((state_q == RX_WAIT) && (rx_bit != START_BIT) &&
                     (tmo_cnt_q == TMO_W'(RX_TIMEOUT))) begin
            rx_timeout = 1'b1;
        end else begin
            rx_valid = 1'b0;
        end
        if (rx_valid) begin
            rx_data = rx_shift_q;
        end else begin
            rx_data = rx_data_q;
        end
    end

    // Link FSM with shift registers, shared bit counter and registered pad controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            pad_din_q  <= IDLE_LEVEL;
            pad_en_q   <= 1'b0;
            pad_ren_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            pad_ren_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        tx_shift_q <= tx_data;
                        pad_en_q   <= 1'b1;
                        pad_din_q  <= START_BIT;
                        tx_ready_q <= 1'b0;
                        state_q    <= TX_START;
                    end
                end
                TX_START: begin
                    pad_din_q  <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    bit_cnt_q  <= '0;
                    state_q    <= TX_DATA;
                end
                TX_DATA: begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        pad_din_q <= STOP_BIT;
                        state_q   <= TX_STOP;
                    end else begin
                        pad_din_q  <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    pad_en_q  <= 1'b0;
                    pad_din_q <= IDLE_LEVEL;
                    bit_cnt_q <= '0;
                    state_q   <= TURN;
                end
                TURN: begin
                    if (bit_cnt_q == CNT_W'(TURN_CYC - 1)) begin
                        tmo_cnt_q <= '0;
                        state_q   <= RX_WAIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                RX_WAIT: begin
                    if (rx_bit == START_BIT) begin
                        bit_cnt_q <= '0;
                        state_q   <= RX_DATA;
                    end else if (tmo_cnt_q == TMO_W'(RX_TIMEOUT)) begin
                        tx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                RX_DATA: begin
                    rx_shift_q <= {rx_bit, rx_shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= RX_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_bit == STOP_BIT) begin
                        rx_data_q <= rx_shift_q;
                    end
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    pad_en_q   <= 1'b0;
                    pad_din_q  <= IDLE_LEVEL;
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = ~tx_ready_q;
    assign pad_din  = pad_din_q;
    assign pad_en   = pad_en_q;
    assign pad_ren  = pad_ren_q;

endmodule

// File: tb/tb_bidir_pad_link.sv
// Self-checking bench for bidir_pad_link: vector table plus hand-written corner
// sequences, with a scoreboard queue matched against the terminal pulses.
module tb_bidir_pad_link;

    localparam int DATA_W     = 8;
    localparam int TURN_CYC   = 2;
    localparam int RX_TIMEOUT = 255;
    localparam int K_VALID    = 0;
    localparam int K_FRAME    = 1;
    localparam int K_TMO      = 2;

    typedef struct {
        logic [7:0] tx;
        bit         resp_en;
        logic [7:0] resp_byte;
        logic       resp_stop;
        int         delay;
        int         exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_timeout;
    logic       busy;
    logic       pad_din;
    logic       pad_en;
    logic       pad_ren;
    logic       pad_dout;
    logic       resp_line = 1'b1;
    logic       force_low = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_pulse_cyc = 0;
    exp_t sb_q[$];
    int   mon_n;
    int   mon_kind;
    exp_t mon_e;
    vec_t tbl[5];

    // Pad model: own driver loops back when enabled, otherwise the far end drives.
    assign pad_dout = force_low ? 1'b0 : (pad_en ? pad_din : resp_line);

    bidir_pad_link #(
        .DATA_W     (DATA_W),
        .TURN_CYC   (TURN_CYC),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_timeout   (rx_timeout),
        .busy         (busy),
        .pad_din      (pad_din),
        .pad_en       (pad_en),
        .pad_ren      (pad_ren),
        .pad_dout     (pad_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Scoreboard: every terminal pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        mon_n = int'(rx_valid) + int'(rx_frame_err) + int'(rx_timeout);
        if (mon_n != 0) begin
            chk("pulse_exclusive", 32'(mon_n), 32'd1);
            mon_kind = rx_valid ? K_VALID : (rx_frame_err ? K_FRAME : K_TMO);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d, expected no pulse (cycle %0d)", mon_kind, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
                chk("rx_data", 32'(rx_data), 32'(mon_e.data));
            end
        end
    end

    task automatic run_frame(input vec_t v, input bit forced, input bit chained);
        int         n;
        int         t_xfer;
        int         ref_cyc;
        int         exp_lat;
        logic [9:0] din_seq;
        logic [9:0] en_seq;
        logic [9:0] ren_seq;
        logic [9:0] exp_seq;
        exp_t       e;
        tx_valid = 1'b1;
        tx_data  = v.tx;
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("accept_in_budget", n < 50, 1'b1);
        t_xfer = cyc;
        if (chained) chk("b2b_turnaround", t_xfer - last_pulse_cyc, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            din_seq[k] = pad_din;
            en_seq[k]  = pad_en;
            ren_seq[k] = pad_ren;
            // Low level timed so it reaches the synchroniser output during TURN.
            if (forced && k == 8) force_low = 1'b1;
        end
        exp_seq = {1'b1, v.tx, 1'b0};
        chk("pad_din_seq", 32'(din_seq), 32'(exp_seq));
        chk("pad_en_tx", 32'(en_seq), 32'h3FF);
        chk("pad_ren_tx", 32'(ren_seq), 32'h3FF);
        @(negedge clk);
        force_low = 1'b0;
        chk1("pad_en_turn", pad_en, 1'b0);
        chk1("pad_din_turn", pad_din, 1'b1);
        for (int k = 0; k < TURN_CYC; k++) @(negedge clk);
        chk1("busy_rx_wait", busy, 1'b1);
        e.kind = v.exp_kind;
        e.data = v.exp_data;
        if (v.resp_en) begin
            for (int k = 0; k < v.delay; k++) @(negedge clk);
            sb_q.push_back(e);
            ref_cyc   = cyc;
            exp_lat   = 3 + DATA_W;
            resp_line = 1'b0;
            for (int i = 0; i < DATA_W; i++) begin
                @(negedge clk);
                resp_line = v.resp_byte[i];
            end
            @(negedge clk);
            resp_line = v.resp_stop;
            @(negedge clk);
            resp_line = 1'b1;
        end else begin
            sb_q.push_back(e);
            ref_cyc = cyc;
            exp_lat = RX_TIMEOUT;
        end
        n = 0;
        while (!(rx_valid || rx_frame_err || rx_timeout) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1("pulse_in_budget", n < 400, 1'b1);
        chk("pulse_latency", cyc - ref_cyc, exp_lat);
        chk1("ready_low_at_pulse", tx_ready, 1'b0);
        last_pulse_cyc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         n;
        tbl[0] = '{tx:8'hA5, resp_en:1'b1, resp_byte:8'h5A, resp_stop:1'b1, delay:3,   exp_kind:K_VALID, exp_data:8'h5A};
        tbl[1] = '{tx:8'h00, resp_en:1'b0, resp_byte:8'h00, resp_stop:1'b1, delay:0,   exp_kind:K_TMO,   exp_data:8'h5A};
        tbl[2] = '{tx:8'hC3, resp_en:1'b1, resp_byte:8'hFF, resp_stop:1'b0, delay:0,   exp_kind:K_FRAME, exp_data:8'h5A};
        tbl[3] = '{tx:8'hFF, resp_en:1'b1, resp_byte:8'h81, resp_stop:1'b1, delay:0,   exp_kind:K_VALID, exp_data:8'h81};
        tbl[4] = '{tx:8'h3C, resp_en:1'b1, resp_byte:8'h00, resp_stop:1'b1, delay:253, exp_kind:K_VALID, exp_data:8'h00};

        @(negedge clk);
        chk1("rst_tx_ready", tx_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_pad_en", pad_en, 1'b0);
        chk1("rst_pad_din", pad_din, 1'b1);
        chk1("rst_pad_ren", pad_ren, 1'b1);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1("idle_pad_en", pad_en, 1'b0);
            chk1("idle_pad_din", pad_din, 1'b1);
            chk1("idle_tx_ready", tx_ready, 1'b1);
            chk1("idle_no_pulse", rx_valid | rx_frame_err | rx_timeout, 1'b0);
        end

        for (int i = 0; i < 5; i++) run_frame(tbl[i], 1'b0, i > 0);

        // Line held low so the synchroniser shows 0 only while in TURN.
        run_frame('{tx:8'h96, resp_en:1'b1, resp_byte:8'h77, resp_stop:1'b1, delay:5,
                    exp_kind:K_VALID, exp_data:8'h77}, 1'b1, 1'b1);

        // Reset while data bit 3 is on the pad.
        b = 8'hC9;
        tx_valid = 1'b1;
        tx_data  = b;
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("rst_seq_accept", n < 50, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk1("bit3_pad_en", pad_en, 1'b1);
        chk1("bit3_pad_din", pad_din, b[3]);
        reset = 1'b1;
        #1;
        chk1("async_pad_en", pad_en, 1'b0);
        chk1("async_pad_din", pad_din, 1'b1);
        chk1("async_tx_ready", tx_ready, 1'b1);
        chk("async_rx_data", 32'(rx_data), 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk1("rst_no_pulse", rx_valid | rx_frame_err | rx_timeout, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        run_frame('{tx:8'h3C, resp_en:1'b1, resp_byte:8'hE1, resp_stop:1'b1, delay:2,
                    exp_kind:K_VALID, exp_data:8'hE1}, 1'b0, 1'b0);
        @(negedge clk);
        chk1("final_tx_ready", tx_ready, 1'b1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bidir_pad_link.md
# bidir_pad_link

Half-duplex single-wire link controller that drives one bidirectional pad, the opposite direction to the fixed input and output pads in the chip padring. It accepts a byte from the core, serialises it out through the pad's output driver, turns the pad around, and receives one response frame back through the pad's receiver. It sits between core logic and one bidirectional pad instance at chip level, and controls the pad's DIN/EN/R_EN and reads its DOUT.

## Interface

Parameters:
- DATA_W, 8: payload bits per frame.
- TURN_CYC, 2: cycles with the driver off between TX stop bit and RX listening; must be ≥1.
- RX_TIMEOUT, 255: maximum RX_WAIT cycles before giving up; must be ≥1.

Ports:
- clk  in  1  sole clock; pad bit rate is one bit per clk.
- reset  in  1  asynchronous, active-high.
- tx_valid  in  1  core has a byte to send.
- tx_ready  out  1  high only in IDLE; transfer when tx_valid && tx_ready.
- tx_data  in  DATA_W  byte to send; sampled on the transfer cycle.
- rx_valid  out  1  one-cycle pulse; rx_data is valid.
- rx_data  out  DATA_W  received byte; holds its value until the next rx_valid.
- rx_frame_err  out  1  one-cycle pulse; the stop bit was sampled 0.
- rx_timeout  out  1  one-cycle pulse; no start bit arrived within RX_TIMEOUT.
- busy  out  1  equals !tx_ready.
- pad_din  out  1  to pad DIN.
- pad_en  out  1  to pad EN (output driver enable).
- pad_ren  out  1  to pad R_EN (receiver enable).
- pad_dout  in  1  from pad DOUT; treated as asynchronous.

## Operation

- Frame format: start bit 0, then DATA_W data bits LSB first, then stop bit 1. Line idles at 1.
- The pad_dout input passes through a 2-flop synchroniser with reset value 1. All RX decisions use the synchronised value only.
- States: IDLE, TX_START, TX_DATA, TX_STOP, TURN, RX_WAIT, RX_DATA, RX_STOP.
- IDLE: pad_en=0, pad_din=1, pad_ren=1, tx_ready=1. A transfer latches tx_data into the shift register and moves to TX_START.
- TX_START, 1 cycle: pad_en=1, pad_din=0.
- TX_DATA, DATA_W cycles: pad_din = shift[0]; shift right each cycle.
- TX_STOP, 1 cycle: pad_din=1.
- TURN, TURN_CYC cycles: pad_en=0, pad_din=1. Synchronised input is ignored.
- RX_WAIT: a timeout counter (width $clog2(RX_TIMEOUT+1)) is cleared on entry and increments each cycle.
  - Synchronised input 0 → RX_DATA.
  - Counter reaches RX_TIMEOUT with no start bit → pulse rx_timeout, go to IDLE.
- RX_DATA, DATA_W cycles: shift the synchronised bit into the MSB, shifting right (LSB-first reassembly).
- RX_STOP, 1 cycle:
  - Synchronised bit 1 → load rx_data, pulse rx_valid.
  - Synchronised bit 0 → pulse rx_frame_err; rx_data is unchanged.
  - Either way, go to IDLE.
- rx_valid, rx_frame_err and rx_timeout are mutually exclusive.
- tx_valid outside IDLE is ignored. The requester holds it, and it is accepted on the next IDLE cycle, including the cycle immediately after returning to IDLE.
- pad_ren is held 1 in every state. Loopback of own TX is harmless because RX_WAIT is only entered after TURN.

## Timing

- Reset values: tx_ready=1, busy=0, pad_en=0, pad_din=1, pad_ren=1, rx_valid=0, rx_frame_err=0, rx_timeout=0, rx_data=0, synchroniser=11, state=IDLE.
- Transfer on cycle T gives:
  - start bit on T+1
  - data bit i on T+2+i
  - stop bit on T+2+DATA_W
  - TURN on T+3+DATA_W … T+2+DATA_W+TURN_CYC
  - RX_WAIT from T+3+DATA_W+TURN_CYC
- All pad_* outputs are registered (flop outputs, no combinational path from inputs).
- RX latency: a start bit presented on pad_dout at cycle S is seen in RX_WAIT at S+2. rx_valid asserts at S+3+DATA_W.
- Reset asserted mid-frame: pad_en drops to 0 asynchronously. No rx_valid, rx_frame_err or rx_timeout pulse is produced, and rx_data is cleared.
- Minimum turnaround: a back-to-back transfer is accepted on the first IDLE cycle after any terminal pulse.

## Structure

- Package bidir_pad_pkg holds:
  - the state enum (bidir_state_t)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
- Sub-module pad_sync: 2-flop synchroniser with a reset-value parameter, instantiated once for pad_dout.
- The top module contains the FSM, one shared bit counter, the TX/RX shift registers and the timeout counter.

## Test plan

- Reset, then idle for 10 cycles → pad_en=0, pad_din=1, tx_ready=1, no pulses.
- Send 8'hA5 with a bench responder echoing 8'h5A after 3 cycles in RX_WAIT:
  - pad_din sequence 0,1,0,1,0,0,1,0,1,1
  - rx_valid pulses with rx_data=8'h5A
  - tx_ready returns 1 on the next cycle
- Send 8'h00 with no response → rx_timeout pulses exactly RX_TIMEOUT cycles after RX_WAIT entry; rx_data is unchanged.
- Responder sends 8'hFF with stop bit 0 → rx_frame_err pulses, no rx_valid, rx_data holds its previous value.
- Bench holds pad_dout=0 during TURN, then releases it to 1 → no false start; RX_WAIT still waits for a real start.
- Assert reset during TX_DATA bit 3 → pad_en is 0 before the next clk edge, no pulses, and a new 8'h3C transfer completes normally after release.
